// File: rtl/uart_tx_queue.sv
// UART transmitter with a small byte FIFO in front of the serializer.
// Frame format and bit time are latched per frame when the head byte is popped.
module uart_tx_queue #(
    parameter int DEPTH_LOG2 = 2,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic [DIV_WIDTH-1:0] i_baud_div,
    input  logic [1:0]           i_parity,
    input  logic [3:0]           i_data_width,
    input  logic                 i_store_req,
    input  logic [7:0]           i_data,
    output logic                 o_full,
    output logic                 o_empty,
    output logic                 o_busy,
    output logic                 o_overflow,
    output logic                 o_tx
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   count, count_next;
    state_t                state;
    logic [DIV_WIDTH-1:0]  div_q, div_cnt;
    logic [7:0]            shift;
    logic [3:0]            width_q, width_eff;
    logic [2:0]            bit_cnt;
    logic                  par_en, par_bit;
    logic                  push, pop, tick;
    logic [7:0]            head_masked;

    assign tick = (div_cnt == div_q);
    assign push = i_store_req && !o_full;
    assign pop  = !o_empty && ((state == IDLE) || ((state == STOP) && tick));

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + 1'b1;
        else if (pop && !push)
            count_next = count - 1'b1;

        if (i_data_width < 4'd5)
            width_eff = 4'd5;
        else if (i_data_width > 4'd8)
            width_eff = 4'd8;
        else
            width_eff = i_data_width;
        head_masked = mem[rd_ptr] & (8'hFF >> (4'd8 - width_eff));
    end

    // NOTE: storage has no reset; only the pointers and count define what is valid.
    always_ff @(posedge i_clock) begin
        if (push)
            mem[wr_ptr] <= i_data;
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_full     <= 1'b0;
            o_empty    <= 1'b1;
            o_overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count      <= count_next;
            o_full     <= (count_next == FULL_COUNT);
            o_empty    <= (count_next == '0);
            o_overflow <= i_store_req && o_full;
        end
    end

    // o_tx and o_busy follow the state one clock later, giving the two-edge strobe-to-start latency.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state   <= IDLE;
            div_cnt <= '0;
            div_q   <= '0;
            shift   <= '0;
            width_q <= 4'd8;
            bit_cnt <= '0;
            par_en  <= 1'b0;
            par_bit <= 1'b0;
            o_tx    <= 1'b1;
            o_busy  <= 1'b0;
        end else begin
            o_busy <= (state != IDLE);
            case (state)
                START:   o_tx <= 1'b0;
                DATA:    o_tx <= shift[0];
                PARITY:  o_tx <= par_bit;
                default: o_tx <= 1'b1;
            endcase

            if (state != IDLE)
                div_cnt <= tick ? '0 : div_cnt + 1'b1;

            if (pop) begin
                shift   <= mem[rd_ptr];
                width_q <= width_eff;
                div_q   <= i_baud_div;
                par_en  <= (i_parity == 2'd1) || (i_parity == 2'd2);
                par_bit <= (i_parity == 2'd2) ? ^head_masked : ~^head_masked;
                bit_cnt <= '0;
                div_cnt <= '0;
                state   <= START;
            end else if ((state != IDLE) && tick) begin
                case (state)
                    START: state <= DATA;
                    DATA: begin
                        shift   <= shift >> 1;
                        bit_cnt <= bit_cnt + 1'b1;
                        if ({1'b0, bit_cnt} == width_q - 4'd1)
                            state <= par_en ? PARITY : STOP;
                    end
                    PARITY:  state <= STOP;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue: a scoreboard of queued bytes is matched
// against frames decoded from o_tx by an independent line monitor.
module tb_uart_tx_queue;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] baud_div;
    logic [1:0]  parity;
    logic [3:0]  data_width;
    logic        store_req;
    logic [7:0]  data;
    logic        full, empty, busy, overflow, tx;

    typedef struct {
        logic [7:0] data;
        int         w;
        int         par;
        int         div;
    } frame_t;

    frame_t sb[$];
    int     starts[$];
    int     n_vec = 0;
    int     n_err = 0;
    bit     mon_active = 1'b0;
    int     mon_cyc = 0;

    uart_tx_queue #(.DEPTH_LOG2(2), .DIV_WIDTH(16)) dut (
        .i_clock      (clk),
        .i_reset      (rst_n),
        .i_baud_div   (baud_div),
        .i_parity     (parity),
        .i_data_width (data_width),
        .i_store_req  (store_req),
        .i_data       (data),
        .o_full       (full),
        .o_empty      (empty),
        .o_busy       (busy),
        .o_overflow   (overflow),
        .o_tx         (tx)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int eff_w(input int w);
        if (w < 5) return 5;
        if (w > 8) return 8;
        return w;
    endfunction

    // Line monitor: decodes each frame at mid-bit using the expected frame's own config.
    initial begin : monitor
        frame_t cur;
        logic   bits [12];
        logic   par;
        int     nbits, t, pos, w;
        nbits = 0; t = 1; pos = 0; w = 8;
        cur = '{8'h00, 8, 0, 0};
        forever begin
            @(negedge clk);
            mon_cyc++;
            if (rst_n !== 1'b1) begin
                mon_active = 1'b0;
            end else begin
                if (!mon_active && tx === 1'b0) begin
                    starts.push_back(mon_cyc);
                    if (sb.size() == 0) begin
                        check("unexpected_frame", 32'(sb.size()), 1);
                    end else begin
                        cur = sb.pop_front();
                        t = cur.div + 1;
                        w = eff_w(cur.w);
                        par = 1'b0;
                        bits[0] = 1'b0;
                        for (int i = 0; i < w; i++) begin
                            bits[1 + i] = cur.data[i];
                            par ^= cur.data[i];
                        end
                        nbits = 2 + w;
                        if (cur.par == 1 || cur.par == 2) begin
                            bits[1 + w] = (cur.par == 2) ? par : ~par;
                            nbits++;
                        end
                        bits[nbits - 1] = 1'b1;
                        pos = 0;
                        mon_active = 1'b1;
                    end
                end
                if (mon_active) begin
                    if (pos % t == cur.div / 2)
                        check($sformatf("frame_%02h_bit%0d", cur.data, pos / t), 32'(tx), 32'(bits[pos / t]));
                    pos++;
                    if (pos == nbits * t)
                        mon_active = 1'b0;
                end
            end
        end
    end

    // Called at a negedge; raises the strobe for exactly the next rising edge.
    task automatic push_byte(input logic [7:0] d, input bit expect_frame);
        store_req = 1'b1;
        data = d;
        if (expect_frame)
            sb.push_back('{d, int'(data_width), int'(parity), int'(baud_div)});
        @(negedge clk);
        store_req = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!(sb.size() == 0 && !mon_active && !busy && empty) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, 32'(n < budget), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx"}, 32'(tx), 1);
        check({tag, "_empty"}, 32'(empty), 1);
        check({tag, "_full"}, 32'(full), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_overflow"}, 32'(overflow), 0);
    endtask

    initial begin
        rst_n = 1'b0; store_req = 1'b0; data = 8'h00;
        baud_div = 16'd3; parity = 2'd0; data_width = 4'd8;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        #3 rst_n = 1'b1;
        @(negedge clk);

        // 0x55, 8N1, 4 clocks per bit; strobe-to-start latency and o_busy window
        push_byte(8'h55, 1'b1);
        check("t2_tx_n0", 32'(tx), 1);
        check("t2_empty_n0", 32'(empty), 0);
        @(negedge clk);
        check("t2_tx_n1", 32'(tx), 1);
        check("t2_busy_n1", 32'(busy), 0);
        @(negedge clk);
        check("t2_tx_n2", 32'(tx), 0);
        check("t2_busy_n2", 32'(busy), 1);
        repeat (39) @(negedge clk);
        check("t2_busy_n41", 32'(busy), 1);
        @(negedge clk);
        check("t2_busy_n42", 32'(busy), 0);
        check("t2_tx_n42", 32'(tx), 1);
        wait_done("t2", 100);

        // 0x03, 7 bits, odd parity, one clock per bit
        baud_div = 16'd0; data_width = 4'd7; parity = 2'd1;
        @(negedge clk);
        push_byte(8'h03, 1'b1);
        wait_done("t3", 100);

        // Fill the FIFO, overflow on the sixth strobe, then five gapless frames
        baud_div = 16'd15; data_width = 4'd8; parity = 2'd0;
        @(negedge clk);
        starts.delete();
        for (int i = 1; i <= 5; i++)
            push_byte(8'(i), 1'b1);
        check("t4_full", 32'(full), 1);
        push_byte(8'h06, 1'b0);
        check("t4_overflow_on", 32'(overflow), 1);
        check("t4_full_hold", 32'(full), 1);
        @(negedge clk);
        check("t4_overflow_off", 32'(overflow), 0);
        wait_done("t4", 5 * 160 + 100);
        check("t4_frames", 32'(starts.size()), 5);
        for (int i = 1; i < 5 && i < starts.size(); i++)
            check($sformatf("t4_gap%0d", i), 32'(starts[i] - starts[i - 1]), 160);

        // Width changes mid-frame: first frame keeps 8 bits, second uses 5
        baud_div = 16'd2; data_width = 4'd8; parity = 2'd2;
        @(negedge clk);
        push_byte(8'hC3, 1'b1);
        push_byte(8'hE6, 1'b1);
        sb[1].w = 5;
        repeat (4) @(negedge clk);
        data_width = 4'd5;
        wait_done("t5", 200);

        // Asynchronous reset with bytes queued and the line low in a frame
        baud_div = 16'd15; data_width = 4'd8; parity = 2'd0;
        @(negedge clk);
        push_byte(8'h00, 1'b1);
        push_byte(8'h22, 1'b1);
        push_byte(8'h33, 1'b1);
        repeat (20) @(negedge clk);
        check("t1_tx_before", 32'(tx), 0);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("t1_async");
        sb.delete();
        @(negedge clk);
        #3 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("t1_tx_idle", 32'(tx), 1);

        // Reset mid-DATA, then a clean 0xA5 frame
        baud_div = 16'd3;
        @(negedge clk);
        push_byte(8'h00, 1'b1);
        repeat (16) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("t6_tx_async", 32'(tx), 1);
        check("t6_busy_async", 32'(busy), 0);
        sb.delete();
        @(negedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        push_byte(8'hA5, 1'b1);
        wait_done("t6", 100);

        // Width clamping and parity mode 3
        baud_div = 16'd1; data_width = 4'd3; parity = 2'd3;
        @(negedge clk);
        push_byte(8'hF6, 1'b1);
        wait_done("t7a", 100);
        data_width = 4'd12; parity = 2'd1;
        @(negedge clk);
        push_byte(8'h80, 1'b1);
        wait_done("t7b", 100);

        check("end_empty", 32'(empty), 1);
        check("end_full", 32'(full), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
